// File: rtl/alu_result_display_pkg.sv
// Shared constants for the ALU result display: segment codes, digit slots,
// conversion FSM encoding and small decode helpers.
package alu_result_display_pkg;

  localparam int DATA_W = 8;
  localparam int BCD_W  = 12;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Active-low {g,f,e,d,c,b,a} patterns for decimal digits 0..9.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  localparam logic [1:0] DIG_ONES = 2'd0;
  localparam logic [1:0] DIG_TENS = 2'd1;
  localparam logic [1:0] DIG_HUND = 2'd2;
  localparam logic [1:0] DIG_SIGN = 2'd3;

  typedef enum logic {IDLE, CONV} state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    s = SEG_BLANK;
    if (d < 4'd10) s = SEG_DIGIT[d];
    return s;
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/alu_result_display_if.sv
// ALU result bus as seen by the display: load strobe and sign-magnitude
// value in, conversion status and multiplexed display drive out.
interface alu_result_display_if;
  logic       load;
  logic [7:0] opc;
  logic       signc;
  logic       busy;
  logic       done;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (output load, opc, signc, input busy, done, an, seg, dp);
  modport slave  (input load, opc, signc, output busy, done, an, seg, dp);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter, one shift-add-3 step
// per clock, MSB first. The bcd output only changes when a conversion ends.
module bin2bcd_seq
  import alu_result_display_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              done,
  output logic              last,
  output logic [BCD_W-1:0]  bcd
);

  state_t            state;
  logic [2:0]        step;
  logic [DATA_W-1:0] sr;
  logic [BCD_W-1:0]  acc;
  logic [BCD_W-1:0]  acc_next;
  logic [BCD_W-1:0]  adj;

  always_comb begin
    adj      = {add3(acc[11:8]), add3(acc[7:4]), add3(acc[3:0])};
    acc_next = {adj[BCD_W-2:0], sr[DATA_W-1]};
  end

  assign last = (state == CONV) && (step == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      step  <= 3'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= CONV;
            busy  <= 1'b1;
            step  <= 3'd0;
          end
        end
        CONV: begin
          step <= step + 3'd1;
          if (step == 3'd7) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            bcd   <= acc_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Working registers are fully reloaded on every start, so no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      sr  <= din;
      acc <= '0;
    end else if (state == CONV) begin
      sr  <= {sr[DATA_W-2:0], 1'b0};
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/alu_result_display.sv
// Display end of the ALU result bus: converts the committed result to BCD
// and scans it onto a 4-digit active-low 7-segment display with blanking.
module alu_result_display
  import alu_result_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_result_display_if.slave  bus
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic             busy;
  logic             done;
  logic             last;
  logic [BCD_W-1:0] bcd;
  logic             sign_cap;
  logic             neg;
  logic             show_minus;
  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic             scan_on;
  logic [1:0]       idx;
  logic [3:0]       an;
  logic [6:0]       seg;
  logic [3:0]       an_nxt;
  logic [6:0]       seg_nxt;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (bus.load),
    .din   (bus.opc),
    .busy  (busy),
    .done  (done),
    .last  (last),
    .bcd   (bcd)
  );

  always_ff @(posedge clk) begin
    if (bus.load && !busy) sign_cap <= bus.signc;
  end

  // A zero result never shows a minus sign, whatever signc was.
  assign show_minus = neg && (bcd != '0);
  assign wrap       = (cnt == CNT_LAST);

  always_comb begin
    an_nxt  = ~(4'b0001 << idx);
    seg_nxt = SEG_BLANK;
    case (idx)
      DIG_ONES: seg_nxt = seg_decode(bcd[3:0]);
      DIG_TENS: seg_nxt = (bcd[11:4] == 8'd0) ? SEG_BLANK : seg_decode(bcd[7:4]);
      DIG_HUND: seg_nxt = (bcd[11:8] == 4'd0) ? SEG_BLANK : seg_decode(bcd[11:8]);
      DIG_SIGN: seg_nxt = show_minus ? SEG_MINUS : SEG_BLANK;
      default:  seg_nxt = SEG_BLANK;
    endcase
  end

  // The first wrap only enables scanning so the ones digit is shown first;
  // later wraps step to the next digit slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg     <= 1'b0;
      cnt     <= '0;
      scan_on <= 1'b0;
      idx     <= DIG_ONES;
      an      <= 4'b1111;
      seg     <= SEG_BLANK;
    end else begin
      if (last) neg <= sign_cap;
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) begin
        if (scan_on) idx <= idx + 2'd1;
        else         scan_on <= 1'b1;
      end
      if (scan_on) begin
        an  <= an_nxt;
        seg <= seg_nxt;
      end
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.an   = an;
  assign bus.seg  = seg;
  assign bus.dp   = 1'b1;

endmodule
